// File: rtl/game_pkg.sv
// game_pkg: shared tile/direction/state codes, maze geometry, power-pellet table and maze init ROM.
package game_pkg;
  typedef enum logic [1:0] {WALL = 2'b00, WKNP = 2'b01, WKRP = 2'b10, WKGH = 2'b11} tile_e;
  typedef enum logic [1:0] {RT = 2'd0, UP = 2'd1, DN = 2'd2, LT = 2'd3} dir_e;
  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, QRY = 2'd2, EAT = 2'd3} state_e;
  localparam logic [6:0] XTILES = 7'd30;
  localparam logic [6:0] YTILES = 7'd33;
  localparam logic [9:0] NTILES = 10'd990;
  localparam logic [6:0] PP_X [0:3] = '{7'd1, 7'd28, 7'd1, 7'd28};
  localparam logic [6:0] PP_Y [0:3] = '{7'd3, 7'd3, 7'd24, 7'd24};
  function automatic logic [9:0] tile_addr(input logic [6:0] x, input logic [6:0] y);
    return 10'(y) * 10'd30 + 10'(x);
  endfunction
  function automatic logic is_power(input logic [6:0] x, input logic [6:0] y);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) r = r | ((x == PP_X[i]) && (y == PP_Y[i]));
    return r;
  endfunction
  // Maze ROM: bordered field, wrap tunnel on row 14, wall stubs and a ghost-house strip on row 16.
  function automatic logic [1:0] maze_tile(input logic [6:0] x, input logic [6:0] y);
    if (y == 7'd0 || y == YTILES - 7'd1) return WALL;
    if (x == 7'd0 || x == XTILES - 7'd1) return (y == 7'd14) ? WKNP : WALL;
    if ((x % 7'd6) == 7'd3 && y[1:0] == 2'd2) return WALL;
    if (y == 7'd16 && x >= 7'd12 && x <= 7'd17) return WKGH;
    return WKRP;
  endfunction
endpackage

// File: rtl/game_maze_ram.sv
// maze_ram: single-port 1024x2 tile store with synchronous read and write enable.
module maze_ram (
  input  logic       clk,
  input  logic       i_we,
  input  logic       i_re,
  input  logic [9:0] i_addr,
  input  logic [1:0] i_wdata,
  output logic [1:0] o_rdata
);
  logic [1:0] r_mem [0:1023];
  logic [1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/game_maze.sv
// game_maze: maze tile store with ROM init, neighbour queries and pellet consumption.
module game_maze
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       query_valid,
  input  logic [6:0] query_xtile,
  input  logic [6:0] query_ytile,
  input  logic       eat_valid,
  input  logic [6:0] eat_xtile,
  input  logic [6:0] eat_ytile,
  output logic       ready,
  output logic [1:0] tile_info [0:3],
  output logic       info_valid,
  output logic       pellet_eaten,
  output logic       power_pellet,
  output logic [9:0] pellets_left,
  output logic       level_clear
);
  state_e     r_state, w_next;
  logic [2:0] r_cnt;
  logic [9:0] r_iaddr;
  logic [6:0] r_ix, r_iy, r_x, r_y;
  logic [1:0] r_nb [0:3];
  logic [1:0] r_tile [0:3];
  logic       r_info_valid, r_pe, r_pp, r_done;
  logic [9:0] r_pellets;
  logic       w_in_range, w_hit, w_rd_force, w_cap_force, w_we, w_re;
  logic [1:0] w_slot, w_cap_slot, w_cap, w_rdata, w_rom, w_wdata;
  logic [6:0] w_qx, w_qy;
  logic [9:0] w_addr;

  assign w_in_range  = (r_x < XTILES) && (r_y < YTILES);
  assign w_slot      = r_cnt[1:0];
  assign w_cap_slot  = 2'(r_cnt - 3'd1);
  assign w_qx        = (w_slot == RT) ? ((r_x == XTILES - 7'd1) ? 7'd0 : r_x + 7'd1) :
                       (w_slot == LT) ? ((r_x == 7'd0) ? XTILES - 7'd1 : r_x - 7'd1) : r_x;
  assign w_qy        = (w_slot == UP) ? r_y - 7'd1 : (w_slot == DN) ? r_y + 7'd1 : r_y;
  // Off-map slots skip the RAM read and are replaced by WALL when captured one cycle later.
  assign w_rd_force  = !w_in_range || (w_slot == UP && r_y == 7'd0) ||
                       (w_slot == DN && r_y == YTILES - 7'd1);
  assign w_cap_force = !w_in_range || (w_cap_slot == UP && r_y == 7'd0) ||
                       (w_cap_slot == DN && r_y == YTILES - 7'd1);
  assign w_cap       = w_cap_force ? WALL : w_rdata;
  assign w_rom       = maze_tile(r_ix, r_iy);
  assign w_hit       = w_in_range && (w_rdata == WKRP);

  maze_ram u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_re   (w_re),
    .i_addr (w_addr),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );

  always_comb begin
    w_addr  = tile_addr(r_x, r_y);
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_wdata = WKNP;
    case (r_state)
      INIT: begin
        w_addr  = r_iaddr;
        w_we    = !rst && (r_iaddr < NTILES);
        w_wdata = w_rom;
      end
      QRY: begin
        w_addr = tile_addr(w_qx, w_qy);
        w_re   = (r_cnt < 3'd4) && !w_rd_force;
      end
      EAT: begin
        w_re = (r_cnt == 3'd0) && w_in_range;
        w_we = !rst && (r_cnt == 3'd1) && w_hit;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      INIT:    w_next = (r_iaddr == NTILES) ? IDLE : INIT;
      IDLE:    w_next = eat_valid ? EAT : query_valid ? QRY : IDLE;
      QRY:     w_next = (r_cnt == 3'd4) ? IDLE : QRY;
      default: w_next = (r_cnt == 3'd2) ? IDLE : EAT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= INIT;
      r_cnt        <= 3'd0;
      r_iaddr      <= 10'd0;
      r_ix         <= 7'd0;
      r_iy         <= 7'd0;
      r_tile       <= '{WALL, WALL, WALL, WALL};
      r_info_valid <= 1'b0;
      r_pe         <= 1'b0;
      r_pp         <= 1'b0;
      r_pellets    <= 10'd0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= (w_next == r_state) ? r_cnt + 3'd1 : 3'd0;
      r_info_valid <= (r_state == QRY) && (r_cnt == 3'd4);
      r_pe         <= (r_state == EAT) && (r_cnt == 3'd1) && w_hit;
      r_pp         <= (r_state == EAT) && (r_cnt == 3'd1) && w_hit && is_power(r_x, r_y);
      if (r_state == INIT && r_iaddr < NTILES) begin
        r_iaddr <= r_iaddr + 10'd1;
        r_ix    <= (r_ix == XTILES - 7'd1) ? 7'd0 : r_ix + 7'd1;
        r_iy    <= (r_ix == XTILES - 7'd1) ? r_iy + 7'd1 : r_iy;
        if (w_rom == WKRP) r_pellets <= r_pellets + 10'd1;
      end
      if (r_state == INIT && w_next == IDLE) r_done <= 1'b1;
      if (r_state == IDLE) begin
        r_x <= eat_valid ? eat_xtile : query_xtile;
        r_y <= eat_valid ? eat_ytile : query_ytile;
      end
      if (r_state == QRY && r_cnt != 3'd0) r_nb[w_cap_slot] <= w_cap;
      if (r_state == QRY && r_cnt == 3'd4) r_tile <= '{r_nb[0], r_nb[1], r_nb[2], w_cap};
      if (r_state == EAT && r_cnt == 3'd1 && w_hit && r_pellets != 10'd0)
        r_pellets <= r_pellets - 10'd1;
    end
  end

  assign ready        = (r_state == IDLE);
  assign tile_info    = r_tile;
  assign info_valid   = r_info_valid;
  assign pellet_eaten = r_pe;
  assign power_pellet = r_pp;
  assign pellets_left = r_pellets;
  assign level_clear  = r_done && (r_pellets == 10'd0);
endmodule

// File: tb/tb_game_maze.sv
// tb_game_maze: directed scenario checks for game_maze against a bench-side maze model.
module tb_game_maze;
  localparam logic [1:0] WALL = 2'd0, WKNP = 2'd1, WKRP = 2'd2, WKGH = 2'd3;
  localparam int INIT_PELLETS = 822;
  logic       clk = 1'b0, rst = 1'b1, query_valid = 1'b0, eat_valid = 1'b0;
  logic [6:0] query_xtile = 7'd0, query_ytile = 7'd0, eat_xtile = 7'd0, eat_ytile = 7'd0;
  logic       ready, info_valid, pellet_eaten, power_pellet, level_clear;
  logic [1:0] tile_info [0:3];
  logic [9:0] pellets_left;
  logic [1:0] model [0:989];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  game_maze dut (
    .clk(clk), .rst(rst),
    .query_valid(query_valid), .query_xtile(query_xtile), .query_ytile(query_ytile),
    .eat_valid(eat_valid), .eat_xtile(eat_xtile), .eat_ytile(eat_ytile),
    .ready(ready), .tile_info(tile_info), .info_valid(info_valid),
    .pellet_eaten(pellet_eaten), .power_pellet(power_pellet),
    .pellets_left(pellets_left), .level_clear(level_clear)
  );

  function automatic logic [1:0] mtile(input int x, input int y);
    if (y == 0 || y == 32) return WALL;
    if (x == 0 || x == 29) return (y == 14) ? WKNP : WALL;
    if ((x == 3 || x == 9 || x == 15 || x == 21 || x == 27) && (y % 4 == 2)) return WALL;
    if (y == 16 && x >= 12 && x <= 17) return WKGH;
    return WKRP;
  endfunction

  function automatic logic [1:0] exp_nb(input int x, input int y, input int k);
    if (x > 29 || y > 32) return WALL;
    case (k)
      0:       return model[y * 30 + ((x == 29) ? 0 : x + 1)];
      1:       return (y == 0) ? WALL : model[(y - 1) * 30 + x];
      2:       return (y == 32) ? WALL : model[(y + 1) * 30 + x];
      default: return model[y * 30 + ((x == 0) ? 29 : x - 1)];
    endcase
  endfunction

  task automatic model_init;
    for (int y = 0; y < 33; y++)
      for (int x = 0; x < 30; x++) model[y * 30 + x] = mtile(x, y);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_query(input int x, input int y, output int lat);
    query_xtile = 7'(x);
    query_ytile = 7'(y);
    query_valid = 1'b1;
    tick;
    query_valid = 1'b0;
    lat = 0;
    while (info_valid !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
  endtask

  task automatic run_eat(input int x, input int y, output int len, output int pe_n, output int pp_n);
    eat_xtile = 7'(x);
    eat_ytile = 7'(y);
    eat_valid = 1'b1;
    tick;
    eat_valid = 1'b0;
    len = 0;
    pe_n = 0;
    pp_n = 0;
    do begin
      pe_n += (pellet_eaten === 1'b1) ? 1 : 0;
      pp_n += (power_pellet === 1'b1) ? 1 : 0;
      tick;
      len++;
    end while (ready !== 1'b1 && len < 10);
    pe_n += (pellet_eaten === 1'b1) ? 1 : 0;
    pp_n += (power_pellet === 1'b1) ? 1 : 0;
    if (x < 30 && y < 33 && model[y * 30 + x] == WKRP) model[y * 30 + x] = WKNP;
  endtask

  task automatic wait_init(output int n, output int iv_seen);
    n = 0;
    iv_seen = 0;
    while (ready !== 1'b1 && n < 2000) begin
      tick;
      n++;
      if (info_valid === 1'b1) iv_seen++;
    end
  endtask

  task automatic test_reset;
    int n, iv;
    rst = 1'b1;
    repeat (3) tick;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got %b want 0", ready); end
    total++; if (info_valid !== 1'b0) begin bad++; $display("FAIL rst_info_valid got %b want 0", info_valid); end
    total++; if (pellet_eaten !== 1'b0 || power_pellet !== 1'b0) begin bad++; $display("FAIL rst_pulses got %b%b want 00", pellet_eaten, power_pellet); end
    total++; if (pellets_left !== 10'd0) begin bad++; $display("FAIL rst_pellets got %0d want 0", pellets_left); end
    total++; if (level_clear !== 1'b0) begin bad++; $display("FAIL rst_level_clear got %b want 0", level_clear); end
    for (int k = 0; k < 4; k++) begin
      total++; if (tile_info[k] !== WALL) begin bad++; $display("FAIL rst_tile_info[%0d] got %0d want 0", k, tile_info[k]); end
    end
    rst = 1'b0;
    wait_init(n, iv);
    total++; if (n !== 991) begin bad++; $display("FAIL init_latency got %0d want 991", n); end
    total++; if (pellets_left !== 10'(INIT_PELLETS)) begin bad++; $display("FAIL init_pellets got %0d want %0d", pellets_left, INIT_PELLETS); end
    total++; if (level_clear !== 1'b0) begin bad++; $display("FAIL init_level_clear got %b want 0", level_clear); end
  endtask

  task automatic test_query;
    int qx [3] = '{5, 3, 14};
    int qy [3] = '{5, 3, 15};
    int lat;
    for (int i = 0; i < 3; i++) begin
      run_query(qx[i], qy[i], lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL query_latency(%0d,%0d) got %0d want 5", qx[i], qy[i], lat); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL query_ready_at_info got %b want 1", ready); end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (tile_info[k] !== exp_nb(qx[i], qy[i], k)) begin
          bad++; $display("FAIL query(%0d,%0d)_slot%0d got %0d want %0d", qx[i], qy[i], k, tile_info[k], exp_nb(qx[i], qy[i], k));
        end
      end
      tick;
      total++; if (info_valid !== 1'b0) begin bad++; $display("FAIL query_pulse_width got %b want 0", info_valid); end
      total++; if (tile_info[0] !== exp_nb(qx[i], qy[i], 0)) begin bad++; $display("FAIL query_hold got %0d want %0d", tile_info[0], exp_nb(qx[i], qy[i], 0)); end
    end
  endtask

  task automatic test_boundaries;
    int bx [5] = '{0, 3, 40, 29, 3};
    int by [5] = '{14, 0, 3, 14, 32};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_query(bx[i], by[i], lat);
      total++; if (lat !== 5) begin bad++; $display("FAIL bound_latency(%0d,%0d) got %0d want 5", bx[i], by[i], lat); end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (tile_info[k] !== exp_nb(bx[i], by[i], k)) begin
          bad++; $display("FAIL bound(%0d,%0d)_slot%0d got %0d want %0d", bx[i], by[i], k, tile_info[k], exp_nb(bx[i], by[i], k));
        end
      end
      tick;
    end
    run_query(0, 14, lat);
    total++; if (tile_info[3] !== WKNP) begin bad++; $display("FAIL wrap_left got %0d want %0d", tile_info[3], WKNP); end
    tick;
    run_query(40, 3, lat);
    total++; if (tile_info[0] !== WALL || tile_info[1] !== WALL || tile_info[2] !== WALL || tile_info[3] !== WALL) begin
      bad++; $display("FAIL out_of_range got %0d%0d%0d%0d want 0000", tile_info[0], tile_info[1], tile_info[2], tile_info[3]);
    end
    tick;
  endtask

  task automatic test_eat;
    int ex [6]  = '{1, 1, 1, 50, 0, 28};
    int ey [6]  = '{1, 1, 3, 50, 0, 24};
    int epe [6] = '{1, 0, 1, 0, 0, 1};
    int epp [6] = '{0, 0, 1, 0, 0, 1};
    int epl [6] = '{821, 821, 820, 820, 820, 819};
    int len, pe_n, pp_n;
    for (int i = 0; i < 6; i++) begin
      run_eat(ex[i], ey[i], len, pe_n, pp_n);
      total++; if (len !== 3) begin bad++; $display("FAIL eat_len(%0d,%0d) got %0d want 3", ex[i], ey[i], len); end
      total++; if (pe_n !== epe[i]) begin bad++; $display("FAIL eat_pellet(%0d,%0d) got %0d want %0d", ex[i], ey[i], pe_n, epe[i]); end
      total++; if (pp_n !== epp[i]) begin bad++; $display("FAIL eat_power(%0d,%0d) got %0d want %0d", ex[i], ey[i], pp_n, epp[i]); end
      total++; if (pellets_left !== 10'(epl[i])) begin bad++; $display("FAIL eat_count(%0d,%0d) got %0d want %0d", ex[i], ey[i], pellets_left, epl[i]); end
    end
  endtask

  task automatic test_back_to_back;
    int len, pe_n, lat;
    eat_xtile = 7'd6;
    eat_ytile = 7'd5;
    query_xtile = 7'd5;
    query_ytile = 7'd5;
    eat_valid = 1'b1;
    query_valid = 1'b1;
    tick;
    eat_valid = 1'b0;
    len = 0;
    pe_n = 0;
    while (ready !== 1'b1 && len < 10) begin
      pe_n += (pellet_eaten === 1'b1) ? 1 : 0;
      tick;
      len++;
    end
    model[5 * 30 + 6] = WKNP;
    total++; if (len !== 3) begin bad++; $display("FAIL b2b_eat_len got %0d want 3", len); end
    total++; if (pe_n !== 1) begin bad++; $display("FAIL b2b_eat_pulse got %0d want 1", pe_n); end
    total++; if (info_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_info got %b want 0", info_valid); end
    tick;
    query_valid = 1'b0;
    lat = 0;
    while (info_valid !== 1'b1 && lat < 20) begin
      tick;
      lat++;
    end
    total++; if (lat !== 5) begin bad++; $display("FAIL b2b_query_latency got %0d want 5", lat); end
    total++; if (tile_info[0] !== WKNP) begin bad++; $display("FAIL b2b_eaten_tile got %0d want %0d", tile_info[0], WKNP); end
    total++; if (pellets_left !== 10'd818) begin bad++; $display("FAIL b2b_count got %0d want 818", pellets_left); end
    tick;
  endtask

  task automatic test_level_clear;
    int len, pe_n, pp_n, errs;
    errs = 0;
    for (int a = 0; a < 990; a++) begin
      if (model[a] == WKRP) begin
        total++;
        if (level_clear !== 1'b0) begin bad++; $display("FAIL early_level_clear at %0d got %b want 0", a, level_clear); break; end
        run_eat(a % 30, a / 30, len, pe_n, pp_n);
        if (pe_n != 1 || len != 3) errs++;
      end
    end
    total++; if (errs !== 0) begin bad++; $display("FAIL sweep_eats got %0d bad eats want 0", errs); end
    total++; if (pellets_left !== 10'd0) begin bad++; $display("FAIL clear_count got %0d want 0", pellets_left); end
    total++; if (level_clear !== 1'b1) begin bad++; $display("FAIL level_clear got %b want 1", level_clear); end
    run_eat(1, 1, len, pe_n, pp_n);
    total++; if (pe_n !== 0 || pellets_left !== 10'd0) begin bad++; $display("FAIL no_underflow got pulse=%0d count=%0d want 0 0", pe_n, pellets_left); end
    total++; if (level_clear !== 1'b1) begin bad++; $display("FAIL level_clear_hold got %b want 1", level_clear); end
  endtask

  task automatic test_reset_mid_qry;
    int n, iv, lat, len, pe_n, pp_n;
    query_xtile = 7'd5;
    query_ytile = 7'd5;
    query_valid = 1'b1;
    tick;
    query_valid = 1'b0;
    tick;
    tick;
    rst = 1'b1;
    tick;
    total++; if (info_valid !== 1'b0 || ready !== 1'b0) begin bad++; $display("FAIL midqry_rst got iv=%b rdy=%b want 0 0", info_valid, ready); end
    total++; if (pellets_left !== 10'd0 || level_clear !== 1'b0) begin bad++; $display("FAIL midqry_rst_count got %0d lc=%b want 0 0", pellets_left, level_clear); end
    rst = 1'b0;
    wait_init(n, iv);
    model_init;
    total++; if (n !== 991) begin bad++; $display("FAIL reinit_latency got %0d want 991", n); end
    total++; if (iv !== 0) begin bad++; $display("FAIL stray_info_valid got %0d want 0", iv); end
    total++; if (pellets_left !== 10'(INIT_PELLETS)) begin bad++; $display("FAIL reinit_count got %0d want %0d", pellets_left, INIT_PELLETS); end
    run_query(5, 5, lat);
    total++; if (tile_info[0] !== WKRP) begin bad++; $display("FAIL restored_tile got %0d want %0d", tile_info[0], WKRP); end
    tick;
    run_eat(1, 3, len, pe_n, pp_n);
    total++; if (pe_n !== 1 || pp_n !== 1) begin bad++; $display("FAIL restored_power got %0d %0d want 1 1", pe_n, pp_n); end
  endtask

  initial begin
    model_init;
    test_reset;
    test_query;
    test_boundaries;
    test_eat;
    test_back_to_back;
    test_level_clear;
    test_reset_mid_qry;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/game_maze.md
GAME_MAZE -- requirements
Module: game_maze

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on posedge clk.
REQ-002 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-003 SHALL have port query_valid  input  1  neighbour query request.
REQ-004 SHALL have ports query_xtile, query_ytile  input  7 each  tile whose four neighbours are requested.
REQ-005 SHALL have port eat_valid  input  1  Pac-Man entered a tile; consume any pellet there.
REQ-006 SHALL have ports eat_xtile, eat_ytile  input  7 each  tile being eaten.
REQ-007 SHALL have port ready  output  1  high only in IDLE; gates both query and eat acceptance.
REQ-008 SHALL have port tile_info  output  4x2 unpacked [0:3]  neighbour tile codes, order RT, UP, DN, LT.
REQ-009 SHALL have port info_valid  output  1  one-cycle pulse when tile_info is updated.
REQ-010 SHALL have ports pellet_eaten, power_pellet  output  1 each  one-cycle pulses on a pellet consumption.
REQ-011 SHALL have port pellets_left  output  10  remaining pellet count.
REQ-012 SHALL have port level_clear  output  1  high while init is complete and pellets_left == 0.

Function
REQ-013 SHALL hold a 30x33 map, 2 bits per tile: WALL=00, WKNP=01, WKRP=10, WKGH=11; address = y*30 + x (10 bits).
REQ-014 SHALL implement FSM states INIT, IDLE, QRY, EAT.
REQ-015 INIT SHALL copy the package maze ROM into RAM, one tile per cycle, addr 0..989; it SHALL count WKRP tiles into pellets_left and then go to IDLE.
REQ-016 In IDLE with eat_valid high, SHALL accept the eat and go to EAT; eat takes priority over a simultaneous query_valid, which stays pending.
REQ-017 In IDLE with query_valid high and eat_valid low, SHALL accept the query and go to QRY.
REQ-018 QRY SHALL read the RT, UP, DN, LT neighbours from RAM in that order, one read per cycle, with 1-cycle read latency.
- info_valid SHALL pulse for exactly one cycle, 5 clock edges after the accepting edge; the FSM returns to IDLE in the same cycle.
- tile_info SHALL hold its value until the next info_valid.
REQ-019 Neighbour x SHALL wrap horizontally: LT of x=0 is x=29; RT of x=29 is x=0.
- UP of y=0 and DN of y=32 SHALL return WALL without a RAM read; the slot timing is unchanged.
REQ-020 A query with x>29 or y>32 SHALL return all four slots WALL, with the same latency.
REQ-021 EAT SHALL read the tile.
- If it is WKRP: write WKNP, decrement pellets_left, and pulse pellet_eaten.
- If the tile is also one of the four package power-pellet coordinates, power_pellet SHALL pulse in the same cycle.
- Otherwise: no write and no pulse.
- EAT SHALL return to IDLE 3 edges after acceptance; the pulses occur in the last EAT cycle.
- An out-of-range eat coordinate SHALL be a no-op of the same length.
REQ-022 pellets_left SHALL never underflow below 0.
REQ-023 level_clear SHALL be a level output and SHALL remain high until rst.
REQ-024 RAM write and read SHALL never target the same address in the same cycle.

Reset
REQ-025 On rst, outputs SHALL take these values on the next edge: ready=0, info_valid=0, tile_info all WALL, pellet_eaten=0, power_pellet=0, pellets_left=0, level_clear=0.
REQ-026 rst SHALL abort any state, including mid-INIT, mid-QRY and mid-EAT, and restart INIT from addr 0; no partial response pulse SHALL be emitted.
REQ-027 rst held high SHALL keep the block in reset; INIT starts on the first edge with rst low.

Structure
REQ-028 The shared package game_pkg SHALL hold:
- tile codes WALL/WKNP/WKRP/WKGH
- direction codes RT/UP/DN/LT
- XTILES=30, YTILES=33
- the power-pellet coordinate table
- the maze init ROM contents
REQ-029 Storage SHALL be one sub-module maze_ram: single-port, 1024x2, synchronous read, 1-cycle latency, write-enable.

Verification
REQ-030 Reset and init: rst 1 cycle, then wait -> ready rises 990+1 edges after rst falls; pellets_left equals the ROM WKRP count.
REQ-031 Query (5,5) -> info_valid exactly 5 edges after acceptance; tile_info matches ROM at (6,5), (5,4), (5,6), (4,5).
REQ-032 Boundaries:
- query (0,14) -> slot LT = ROM(29,14).
- query (3,0) -> slot UP = WALL.
- query (40,3) -> all four slots WALL.
REQ-033 Eating:
- eat a WKRP tile -> pellet_eaten pulse and pellets_left decremented by 1.
- eat the same tile again -> no pulse and no change.
- eat a power-pellet tile -> pellet_eaten and power_pellet pulse together.
REQ-034 Simultaneous events: eat_valid and query_valid high in the same IDLE cycle -> EAT runs first, the query is accepted on the next IDLE cycle, and the query result reflects the eaten tile as WKNP.
REQ-035 rst asserted mid-QRY -> no info_valid; INIT restarts; previously eaten pellets are restored in RAM and in the count.
